// File: rtl/wb_pkg.sv
// Shared definitions for the write-back unit.
//   sel_e   : result-source encodings carried on in_sel.
//   entry_t : one buffered write-back entry {data, rd, we}.
// entry_t is sized for the widest supported configuration: DATA_W up to
// ENT_DATA_W and ADDR_W up to ENT_ADDR_W. Narrower configurations zero-extend
// into it.
`timescale 1ns/1ps
package wb_pkg;
  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_LINK = 2'd2,
    SEL_RSV  = 2'd3
  } sel_e;

  localparam int ENT_DATA_W = 64;
  localparam int ENT_ADDR_W = 8;

  typedef struct packed {
    logic [ENT_DATA_W-1:0] data;
    logic [ENT_ADDR_W-1:0] rd;
    logic                  we;
  } entry_t;
endpackage

// File: rtl/wb_result_mux.sv
// Combinational result selection for one incoming instruction.
//   sel        : source select (ALU / memory / link / reserved)
//   alu_ans, mux_ans_dm, link_pc : candidate results
//   rd, we     : destination register and write request
//   ent        : resolved entry; the reserved source yields data 0 and no
//                write, and rd 0 never writes
`timescale 1ns/1ps
module wb_result_mux
  import wb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] alu_ans,
  input  logic [DATA_W-1:0] mux_ans_dm,
  input  logic [DATA_W-1:0] link_pc,
  input  logic [ADDR_W-1:0] rd,
  input  logic              we,
  output entry_t            ent
);
  always_comb begin
    ent    = '0;
    ent.rd = ENT_ADDR_W'(rd);
    ent.we = we && (rd != '0);
    case (sel_e'(sel))
      SEL_ALU:  ent.data = ENT_DATA_W'(alu_ans);
      SEL_MEM:  ent.data = ENT_DATA_W'(mux_ans_dm);
      SEL_LINK: ent.data = ENT_DATA_W'(link_pc);
      default: begin
        ent.data = '0;
        ent.we   = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: a 2-entry in-order buffer between execute and the
// register-file write port, plus a retire counter.
//   in_valid/in_ready      : upstream handshake (in_ready depends on state only)
//   in_sel, alu_ans, mux_ans_dm, link_pc, in_rd, in_we : incoming instruction
//   flush                  : synchronous discard of every held entry
//   rf_ready               : register-file port free; pops the head
//   wb_valid, ans_wb, wb_rd, wb_we : head entry (zeroed when empty)
//   fwd_valid, fwd_rd, fwd_data    : youngest held writing entry
//   retire_cnt             : wrapping count of popped entries
`timescale 1ns/1ps
module write_back_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] alu_ans,
  input  logic [DATA_W-1:0] mux_ans_dm,
  input  logic [DATA_W-1:0] link_pc,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_we,
  input  logic              flush,
  input  logic              rf_ready,
  output logic              wb_valid,
  output logic [DATA_W-1:0] ans_wb,
  output logic [ADDR_W-1:0] wb_rd,
  output logic              wb_we,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);
  entry_t             new_ent;
  entry_t             head_q, tail_q, young;
  logic   [1:0]       occ_q;
  logic   [CNT_W-1:0] retire_q;
  logic               push, pop;
  logic               unused_bits;

  wb_result_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux (
    .sel        (in_sel),
    .alu_ans    (alu_ans),
    .mux_ans_dm (mux_ans_dm),
    .link_pc    (link_pc),
    .rd         (in_rd),
    .we         (in_we),
    .ent        (new_ent)
  );

  // in_ready is purely registered state; a pop in the same cycle does not
  // open a slot for a push at occupancy 2.
  assign in_ready = (occ_q != 2'd2);
  assign wb_valid = (occ_q != 2'd0);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = wb_valid && rf_ready && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q    <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
      retire_q <= '0;
    end else begin
      if (pop) retire_q <= retire_q + CNT_W'(1);
      if (flush) begin
        occ_q <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (occ_q == 2'd0) head_q <= new_ent;
            else               tail_q <= new_ent;
            occ_q <= occ_q + 2'd1;
          end
          2'b01: begin
            head_q <= tail_q;
            occ_q  <= occ_q - 2'd1;
          end
          // push+pop only qualifies at occupancy 1: replace the head in place
          2'b11:   head_q <= new_ent;
          default: ;
        endcase
      end
    end
  end

  assign young = (occ_q == 2'd2) ? tail_q : head_q;

  assign ans_wb     = wb_valid ? head_q.data[DATA_W-1:0] : '0;
  assign wb_rd      = wb_valid ? head_q.rd[ADDR_W-1:0]   : '0;
  assign wb_we      = wb_valid && head_q.we;
  assign fwd_valid  = wb_valid && young.we;
  assign fwd_rd     = fwd_valid ? young.rd[ADDR_W-1:0]   : '0;
  assign fwd_data   = fwd_valid ? young.data[DATA_W-1:0] : '0;
  assign retire_cnt = retire_q;

  // Entry fields above the configured widths are always zero.
  assign unused_bits = ^{head_q, tail_q};
endmodule
